// File: rtl/riscv_button_debouncer_multi.sv
// N-channel push-button debouncer: 2-flop synchroniser, per-channel press/release FSM, edge pulses.
// Long-press detection (held/held_pulse) is built only when RISCV_DEBOUNCE_HOLD_EN is defined.
module riscv_button_debouncer_multi #(
  parameter int unsigned N_CH            = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter bit          ACTIVE_LOW      = 1'b0,
  parameter int unsigned HOLD_CYCLES     = 2**24
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] noisy_in,
  output logic [N_CH-1:0] debounced,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse
`ifdef RISCV_DEBOUNCE_HOLD_EN
  ,
  output logic [N_CH-1:0] held,
  output logic [N_CH-1:0] held_pulse
`endif
);

  localparam int unsigned CNT_MAX = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef RISCV_DEBOUNCE_HOLD_EN
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES);
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    PRESSED = 2'd2,
    RELEASE = 2'd3
  } state_t;

  logic [N_CH-1:0] sync1;
  logic [N_CH-1:0] sync2;
  logic [N_CH-1:0] s;

  // Metastability filter; polarity is normalised after the second flop
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= noisy_in;
      sync2 <= sync1;
    end
  end

  assign s = sync2 ^ {N_CH{ACTIVE_LOW}};

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             deb_q;
    logic             deb_nxt;
    logic             rise_q;
    logic             fall_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        state  <= IDLE;
        cnt    <= '0;
        deb_q  <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        state  <= state_nxt;
        cnt    <= cnt_nxt;
        deb_q  <= deb_nxt;
        rise_q <= deb_nxt & ~deb_q;
        fall_q <= ~deb_nxt & deb_q;
      end
    end

    // Terminal compare is tested before the increment, so cnt never wraps
    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
        IDLE: begin
          cnt_nxt = '0;
          if (s[g]) state_nxt = ARM;
        end
        ARM: begin
          if (!s[g])               state_nxt = IDLE;
          else if (cnt == DB_LAST) state_nxt = PRESSED;
          else                     cnt_nxt   = cnt + CNT_W'(1);
        end
        PRESSED: begin
          cnt_nxt = '0;
          if (!s[g]) state_nxt = RELEASE;
        end
        RELEASE: begin
          if (s[g])                state_nxt = PRESSED;
          else if (cnt == DB_LAST) state_nxt = IDLE;
          else                     cnt_nxt   = cnt + CNT_W'(1);
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
      deb_nxt = (state_nxt == PRESSED) || (state_nxt == RELEASE);
    end

    assign debounced[g]  = deb_q;
    assign rise_pulse[g] = rise_q;
    assign fall_pulse[g] = fall_q;

`ifdef RISCV_DEBOUNCE_HOLD_EN
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_nxt;
    logic             held_q;
    logic             held_nxt;
    logic             held_pulse_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        hold_cnt     <= '0;
        held_q       <= 1'b0;
        held_pulse_q <= 1'b0;
      end else begin
        hold_cnt     <= hold_nxt;
        held_q       <= held_nxt;
        held_pulse_q <= held_nxt & ~held_q;
      end
    end

    // Frozen in RELEASE, saturating in PRESSED, cleared together with debounced
    always_comb begin
      hold_nxt = hold_cnt;
      if (!deb_nxt)
        hold_nxt = '0;
      else if ((state == PRESSED) && (hold_cnt != HOLD_MAX))
        hold_nxt = hold_cnt + CNT_W'(1);
      held_nxt = deb_nxt && (hold_nxt == HOLD_MAX);
    end

    assign held[g]       = held_q;
    assign held_pulse[g] = held_pulse_q;
`endif
  end

endmodule
